result_mem_arbiter: RTL and testbench
=====================================

// Module: result_mem_arbiter
// PURPOSE
//  Shares the single-port 16x16 result memory between two requesters: port 0 = CPU
//  write-back, port 1 = debug/readout. Round-robin arbitration, valid/ready request
//  handshake, fixed 1-cycle read response. Owns memory init: zero-fills all words after
//  reset. Sits between the CPU core/debug logic and the result memory instance.
// PARAMETERS
//  ADDR_W   4   memory address width
//  DATA_W   16  memory data width
//  DEPTH    16  words swept by init (must equal 2**ADDR_W)
//  INIT_EN  1   1: zero-fill after reset; 0: enter SERVE directly
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst          in   1       asynchronous active-high reset
//  p0_valid     in   1       port 0 request valid
//  p0_ready     out  1       port 0 request accepted this cycle (comb.)
//  p0_we        in   1       1=write, 0=read
//  p0_addr      in   ADDR_W  port 0 address
//  p0_wdata     in   DATA_W  port 0 write data
//  p0_rvalid    out  1       port 0 read data valid (registered)
//  p0_rdata     out  DATA_W  port 0 read data, valid only with p0_rvalid
//  p1_*         same set as p0_* for port 1
//  mem_addr     out  ADDR_W  to memory addr
//  mem_wdata    out  DATA_W  to memory data_in
//  mem_we       out  1       to memory write_en
//  mem_rdata    in   DATA_W  from memory data_out
//  init_done    out  1       high once zero-fill complete
// BEHAVIOUR
//  - FSM: INIT -> SERVE. Reset enters INIT (INIT_EN=1) else SERVE. INIT: 4-bit counter
//    0..DEPTH-1, mem_we=1, mem_addr=cnt, mem_wdata=0, both readys=0; after word DEPTH-1
//    -> SERVE, init_done=1 next cycle. SERVE is terminal until reset.
//  - Reset values: p*_ready=0, p*_rvalid=0, p*_rdata=0, init_done=0 (1 if INIT_EN=0),
//    rr pointer=port 0 priority, init cnt=0, rd_pending=0. rst mid-INIT or mid-read
//    restarts INIT and drops any pending response (no rvalid emitted).
//  - Grant (SERVE, comb.): eligible = valid && !(we && rd_pending). Both eligible ->
//    port with priority; pointer flips to the other port after each grant. One eligible
//    -> it wins, pointer still flips past the winner. None -> mem_we=0, mem_addr holds 0.
//  - Granted port's ready=1 in that cycle; mem_addr/mem_wdata/mem_we = its fields.
//  - Read latency: read granted in cycle N -> rd_pending=1, owner recorded; in N+1 the
//    arbiter captures mem_rdata into owner's rdata, rvalid pulses 1 cycle in N+2.
//  - Write hazard: memory bypasses data_in to data_out when write_en=1, so no write is
//    granted in cycle N+1 (rd_pending=1); a read may be granted back-to-back (1 rd/cycle).
//  - Read-after-write same address in next cycle returns the new data (memory commits
//    at posedge). Same-cycle conflict impossible (single grant).
//  - Writes produce no response; ready is completion. Requester must hold fields stable
//    while valid && !ready.
// STRUCTURE
//  - Package result_mem_pkg: ADDR_W, DATA_W, DEPTH constants; state enum {INIT,SERVE}.
//  - Sub-module rr_arb2: 2-way round-robin grant + priority pointer (req[1:0] ->
//    gnt[1:0], advance on any grant). Rest (FSM, init counter, response pipe) in top.
// TESTING
//  1 Reset release, INIT_EN=1 -> 16 cycles mem_we=1 addr 0..15 data 0, readys 0,
//    init_done=1 on cycle 17; read of addr 9 returns 16'h0000.
//  2 p0 write addr 3=16'hBEEF, next cycle p1 read addr 3 -> p1_rvalid 2 cycles later,
//    p1_rdata=16'hBEEF.
//  3 Both ports read continuously (p0 addr 1, p1 addr 2) -> grants alternate 0,1,0,1;
//    rvalid alternates each cycle, data matches per port.
//  4 p0 read addr 5 in cycle N, p1 write addr 5=16'h1234 valid in N+1 -> p1_ready=0 in
//    N+1, granted N+2; p0_rdata equals old value (not 16'h1234).
//  5 Assert rst 1 cycle after a read grant -> no rvalid emitted, INIT restarts at addr 0,
//    previously written words read 0 afterwards.
//  6 INIT_EN=0 -> init_done=1 out of reset, p0 request granted first cycle after reset.

Source files
------------

// File: rtl/result_mem_pkg.sv
// result_mem_pkg: shared constants and FSM state encodings for the result memory arbiter.
package result_mem_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; priority flips past the winner on every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prio;
    assign gnt[0] = req[0] && !(req[1] && prio);
    assign gnt[1] = req[1] && !gnt[0];
    always_ff @(posedge clk or posedge rst)
        if (rst) prio <= 1'b0;
        else if (|gnt) prio <= gnt[0];
endmodule

// File: rtl/result_mem_arbiter.sv
// result_mem_arbiter: shares the single-port result memory between CPU write-back and debug readout,
// zero-fills the memory after reset and returns read data one cycle after the memory output.
module result_mem_arbiter #(
    parameter int ADDR_W  = result_mem_pkg::ADDR_W,
    parameter int DATA_W  = result_mem_pkg::DATA_W,
    parameter int DEPTH   = result_mem_pkg::DEPTH,
    parameter int INIT_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              init_done
);
    import result_mem_pkg::*;
    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              rd_pending, owner, serve, in_init;
    logic [1:0]        elig, gnt;
    assign in_init = state == INIT;
    assign serve   = state == SERVE && !rst;
    // The memory bypasses data_in to data_out on writes, so no write may land while a read result is pending.
    assign elig = {serve && p1_valid && !(p1_we && rd_pending),
                   serve && p0_valid && !(p0_we && rd_pending)};
    rr_arb2 u_arb (.clk(clk), .rst(rst), .req(elig), .gnt(gnt));
    assign p0_ready  = gnt[0];
    assign p1_ready  = gnt[1];
    assign init_done = state == SERVE;
    assign mem_we    = in_init || (gnt[0] && p0_we) || (gnt[1] && p1_we);
    assign mem_addr  = in_init ? cnt : gnt[1] ? p1_addr : gnt[0] ? p0_addr : '0;
    assign mem_wdata = in_init ? '0 : gnt[1] ? p1_wdata : gnt[0] ? p0_wdata : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= INIT_EN != 0 ? INIT : SERVE;
            cnt   <= '0;
        end else if (in_init) begin
            cnt <= cnt + 1'b1;
            if (cnt == ADDR_W'(DEPTH - 1)) state <= SERVE;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_pending <= 1'b0;
            owner      <= 1'b0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            rd_pending <= (gnt[0] && !p0_we) || (gnt[1] && !p1_we);
            owner      <= gnt[1];
            p0_rvalid  <= rd_pending && !owner;
            p1_rvalid  <= rd_pending && owner;
            if (rd_pending && !owner) p0_rdata <= mem_rdata;
            if (rd_pending && owner) p1_rdata <= mem_rdata;
        end
endmodule

// File: tb/tb_result_mem_arbiter.sv
// tb_result_mem_arbiter: directed checks of init sweep, arbitration, read latency and write hazard,
// with behavioural write-first memories behind an INIT_EN=1 and an INIT_EN=0 instance.
module tb_result_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
    logic [3:0] p0_addr = 0, p1_addr = 0;
    logic [15:0] p0_wdata = 0, p1_wdata = 0;
    logic p0_ready, p0_rvalid, p1_ready, p1_rvalid, mem_we, init_done;
    logic [15:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [3:0] mem_addr;
    logic b_valid = 0, b_we = 0;
    logic [3:0] b_addr = 0;
    logic [15:0] b_wdata = 0;
    logic b_p0_ready, b_p0_rvalid, b_p1_ready, b_p1_rvalid, b_mem_we, b_init_done;
    logic [15:0] b_p0_rdata, b_p1_rdata, b_mem_wdata, b_mem_rdata;
    logic [3:0] b_mem_addr;
    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    int n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    result_mem_arbiter #(.INIT_EN(1)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .init_done(init_done)
    );

    result_mem_arbiter #(.INIT_EN(0)) dut0 (
        .clk(clk), .rst(rst),
        .p0_valid(b_valid), .p0_ready(b_p0_ready), .p0_we(b_we), .p0_addr(b_addr),
        .p0_wdata(b_wdata), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
        .p1_valid(1'b0), .p1_ready(b_p1_ready), .p1_we(1'b0), .p1_addr(4'd0),
        .p1_wdata(16'd0), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata),
        .init_done(b_init_done)
    );

    // Write-first single-port memories: data_out shows data_in on a write.
    always @(posedge clk) begin
        if (mem_we) begin
            mem_a[mem_addr] <= mem_wdata;
            mem_rdata <= mem_wdata;
        end else mem_rdata <= mem_a[mem_addr];
        if (b_mem_we) begin
            mem_b[b_mem_addr] <= b_mem_wdata;
            b_mem_rdata <= b_mem_wdata;
        end else b_mem_rdata <= mem_b[b_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        p0_valid = 0;
        p1_valid = 0;
    endtask

    task automatic set(input int p, input logic we, input logic [3:0] a, input logic [15:0] d);
        if (p == 0) {p0_valid, p0_we, p0_addr, p0_wdata} = {1'b1, we, a, d};
        else {p1_valid, p1_we, p1_addr, p1_wdata} = {1'b1, we, a, d};
    endtask

    task automatic wait_grant(input int p, input string tag);
        int n = 0;
        #1;
        while (!(p != 0 ? p1_ready : p0_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_rdy"}, 32'(p != 0 ? p1_ready : p0_ready), 1);
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [15:0] d, input string tag);
        @(negedge clk);
        idle();
        set(p, 1'b1, a, d);
        wait_grant(p, tag);
    endtask

    task automatic rd(input int p, input logic [3:0] a, input logic [15:0] exp, input string tag);
        @(negedge clk);
        idle();
        set(p, 1'b0, a, 16'h0);
        wait_grant(p, tag);
        @(negedge clk);
        idle();
        #1;
        check({tag, "_rv_early"}, 32'(p != 0 ? p1_rvalid : p0_rvalid), 0);
        @(negedge clk);
        #1;
        check({tag, "_rv"}, 32'(p != 0 ? p1_rvalid : p0_rvalid), 1);
        check({tag, "_data"}, p != 0 ? p1_rdata : p0_rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state, both instances; requests pending through the init sweep.
        {b_valid, b_we, b_addr, b_wdata} = {1'b1, 1'b1, 4'd4, 16'h4444};
        set(0, 1'b0, 4'd9, 16'h0);
        set(1, 1'b0, 4'd9, 16'h0);
        @(negedge clk);
        #1;
        check("rst_p0_ready", p0_ready, 0);
        check("rst_p0_rvalid", p0_rvalid, 0);
        check("rst_init_done", init_done, 0);
        check("rst_b_init_done", b_init_done, 1);
        check("rst_b_ready", b_p0_ready, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (i == 0) begin
                check("noinit_b_ready", b_p0_ready, 1);
                check("noinit_b_we", b_mem_we, 1);
                check("noinit_b_addr", b_mem_addr, 4);
                b_valid = 0;
            end
            check("init_we", mem_we, 1);
            check("init_addr", mem_addr, i);
            check("init_wdata", mem_wdata, 0);
            check("init_readys", {p1_ready, p0_ready}, 0);
            check("init_done_low", init_done, 0);
            @(negedge clk);
        end
        #1;
        check("c17_init_done", init_done, 1);
        check("c17_p0_ready", p0_ready, 1);
        check("c17_p1_ready", p1_ready, 0);
        check("c17_addr", mem_addr, 9);
        @(negedge clk);
        p0_valid = 0;
        #1;
        check("c18_p1_ready", p1_ready, 1);
        check("c18_p0_rvalid", p0_rvalid, 0);
        @(negedge clk);
        p1_valid = 0;
        #1;
        check("c19_p0_rvalid", p0_rvalid, 1);
        check("c19_p0_rdata", p0_rdata, 0);
        @(negedge clk);
        #1;
        check("c20_p1_rvalid", p1_rvalid, 1);
        check("c20_p1_rdata", p1_rdata, 0);
        // Write then read-after-write from the other port.
        wr(0, 4'd3, 16'hBEEF, "t2_wr");
        rd(1, 4'd3, 16'hBEEF, "t2_rd");
        // Continuous reads from both ports alternate grants.
        wr(0, 4'd1, 16'h1111, "t3_wr1");
        wr(1, 4'd2, 16'h2222, "t3_wr2");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set(0, 1'b0, 4'd1, 16'h0);
            set(1, 1'b0, 4'd2, 16'h0);
            #1;
            check("t3_p0_ready", p0_ready, 32'(k % 2 == 0));
            check("t3_p1_ready", p1_ready, 32'(k % 2 == 1));
            check("t3_p0_rvalid", p0_rvalid, 32'(k >= 2 && k % 2 == 0));
            check("t3_p1_rvalid", p1_rvalid, 32'(k >= 2 && k % 2 == 1));
            if (k >= 2) check("t3_rdata", k % 2 == 0 ? p0_rdata : p1_rdata, k % 2 == 0 ? 16'h1111 : 16'h2222);
        end
        @(negedge clk);
        idle();
        #1;
        check("t3_tail_p0", {p1_rvalid, p0_rvalid}, 2'b01);
        @(negedge clk);
        #1;
        check("t3_tail_p1", {p1_rvalid, p0_rvalid}, 2'b10);
        // Write blocked in the cycle after a read grant.
        wr(0, 4'd5, 16'h5555, "t4_wr");
        @(negedge clk);
        idle();
        set(0, 1'b0, 4'd5, 16'h0);
        #1;
        check("t4_rd_ready", p0_ready, 1);
        @(negedge clk);
        idle();
        set(1, 1'b1, 4'd5, 16'h1234);
        #1;
        check("t4_wr_blocked", p1_ready, 0);
        check("t4_we_blocked", mem_we, 0);
        check("t4_addr_idle", mem_addr, 0);
        @(negedge clk);
        #1;
        check("t4_wr_granted", p1_ready, 1);
        check("t4_wdata", mem_wdata, 16'h1234);
        check("t4_rvalid", p0_rvalid, 1);
        check("t4_old_data", p0_rdata, 16'h5555);
        // Reset right after a read grant drops the response and reruns the sweep.
        wr(0, 4'd7, 16'h7777, "t5_wr");
        @(negedge clk);
        idle();
        set(1, 1'b0, 4'd7, 16'h0);
        #1;
        check("t5_rd_ready", p1_ready, 1);
        @(negedge clk);
        idle();
        rst = 1;
        #1;
        check("t5_rst_rvalid", p1_rvalid, 0);
        check("t5_rst_done", init_done, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("t5_init_addr", mem_addr, i);
            check("t5_no_rvalid", p1_rvalid, 0);
            @(negedge clk);
        end
        rd(0, 4'd7, 16'h0, "t5_rd7");
        rd(1, 4'd3, 16'h0, "t5_rd3");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
